morph_window_seq: RTL and testbench

Sequencer for one 3x3 morphological window stage (line buffer + matrix kernel) in the LCD image pipeline. Per frame it resets the line-buffer FIFOs, preloads two image rows from the picture ROM, then on each display-line request streams one further row while reading the two buffered rows, generating every ROM address, FIFO write/read enable and window-valid strobe from counters instead of screen coordinates. One instance drives each stage (erode, dilate) of the opening pipeline.

---
 rtl/morph_pkg.sv | 22 ++
 rtl/morph_delay_line.sv | 36 +++
 rtl/morph_window_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_morph_window_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// Types and defaults shared by the morphological window stages (sequencer,
// line buffer, kernel).
package morph_pkg;

    localparam int MORPH_PIC_WIDTH  = 250;
    localparam int MORPH_PIC_HEIGHT = 250;
    localparam int MORPH_ADDR_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_WAIT_RB = 3'd2,
        ST_PRELOAD = 3'd3,
        ST_READY   = 3'd4,
        ST_LINE    = 3'd5
    } morph_state_e;

    function automatic logic is_busy_state(input morph_state_e st);
        return !((st == ST_IDLE) || (st == ST_READY));
    endfunction

endpackage

// File: rtl/morph_delay_line.sv
// 1-bit shift register of DEPTH stages with synchronous flush; the output is
// the last flop, so it is always registered.
module morph_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic lcd_pclk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = '0;
        if (!flush) begin
            sr_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/morph_window_seq.sv
// Address/enable sequencer for one 3x3 morphological window stage.
// Define MORPH_SEQ_OVERRUN_EN to get a sticky flag for stray line requests.
//
// state   | meaning
// IDLE    | waiting for frame_start
// FLUSH   | line-buffer FIFOs held in reset for RST_CYC cycles
// WAIT_RB | waiting for the FIFOs to leave reset
// PRELOAD | issuing the first two image rows (writes only)
// READY   | two rows buffered, waiting for line_req
// LINE    | issuing one row while the buffered rows are read out
module morph_window_seq
    import morph_pkg::*;
#(
    parameter int PIC_WIDTH  = MORPH_PIC_WIDTH,
    parameter int PIC_HEIGHT = MORPH_PIC_HEIGHT,
    parameter int ADDR_W     = MORPH_ADDR_W,
    parameter int ROM_LAT    = 1,
    parameter int RST_CYC    = 4
) (
    input  logic              lcd_pclk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              line_req,
    input  logic              fifo_rst_busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              buf_wr_en,
    output logic              buf_rd_en,
    output logic              win_valid,
    output logic              fifo_rst_n,
    output logic              line_done,
    output logic              frame_done,
    output logic              busy,
    output logic              err_overrun
);

    localparam int COL_W = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam int ROW_W = $clog2(PIC_HEIGHT);
    localparam int CNT_W = $clog2(RST_CYC + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIC_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PIC_HEIGHT - 3);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC - 1);

    morph_state_e      state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic              pre_row_q, pre_row_d;
    logic              issue_q, issue_d;
    logic              rd_issue_q, rd_issue_d;
    logic              fifo_rst_n_q, fifo_rst_n_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              abort;

    // Only a restart mid-frame discards in-flight enables; in IDLE the tail of
    // the final row is still draining and must reach the line buffer.
    assign abort = frame_start && (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        col_d        = col_q;
        row_d        = row_q;
        rst_cnt_d    = rst_cnt_q;
        pre_row_d    = pre_row_q;
        issue_d      = 1'b0;
        rd_issue_d   = 1'b0;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;

        if (frame_start) begin
            state_d   = ST_FLUSH;
            rst_cnt_d = RST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_FLUSH: begin
                    if (rst_cnt_q == '0) begin
                        state_d = ST_WAIT_RB;
                    end else begin
                        rst_cnt_d = rst_cnt_q - CNT_W'(1);
                    end
                end
                ST_WAIT_RB: begin
                    if (!fifo_rst_busy) begin
                        rom_addr_d = '0;
                        issue_d    = 1'b1;
                        col_d      = '0;
                        row_d      = '0;
                        pre_row_d  = 1'b0;
                        state_d    = ST_PRELOAD;
                    end
                end
                ST_PRELOAD: begin
                    if ((col_q == COL_LAST) && pre_row_q) begin
                        col_d   = '0;
                        state_d = ST_READY;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        issue_d    = 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d     = '0;
                            pre_row_d = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                ST_READY: begin
                    if (line_req) begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        issue_d    = 1'b1;
                        rd_issue_d = 1'b1;
                        col_d      = '0;
                        state_d    = ST_LINE;
                    end
                end
                ST_LINE: begin
                    if (col_q == COL_LAST) begin
                        col_d       = '0;
                        line_done_d = 1'b1;
                        if (row_q == ROW_LAST) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = ST_READY;
                        end
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        issue_d    = 1'b1;
                        rd_issue_d = 1'b1;
                        col_d      = col_q + COL_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        fifo_rst_n_d = (state_d != ST_FLUSH);
        busy_d       = is_busy_state(state_d);
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rom_addr_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            rst_cnt_q    <= '0;
            pre_row_q    <= 1'b0;
            issue_q      <= 1'b0;
            rd_issue_q   <= 1'b0;
            fifo_rst_n_q <= 1'b1;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            rst_cnt_q    <= rst_cnt_d;
            pre_row_q    <= pre_row_d;
            issue_q      <= issue_d;
            rd_issue_q   <= rd_issue_d;
            fifo_rst_n_q <= fifo_rst_n_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // Read enables are tagged at issue time, so a row's reads follow its
    // writes through the ROM latency even after the FSM has left LINE.
    morph_delay_line #(.DEPTH(ROM_LAT)) u_wr_dly (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .flush    (abort),
        .din      (issue_q),
        .dout     (buf_wr_en)
    );

    morph_delay_line #(.DEPTH(ROM_LAT)) u_rd_dly (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .flush    (abort),
        .din      (rd_issue_q),
        .dout     (buf_rd_en)
    );

    morph_delay_line #(.DEPTH(1)) u_win_dly (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .flush    (abort),
        .din      (buf_rd_en),
        .dout     (win_valid)
    );

`ifdef MORPH_SEQ_OVERRUN_EN
    logic err_overrun_q, err_overrun_d;

    always_comb begin
        err_overrun_d = err_overrun_q;
        if (frame_start) begin
            err_overrun_d = 1'b0;
        end else if (line_req && (state_q != ST_IDLE) && (state_q != ST_READY)) begin
            err_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            err_overrun_q <= 1'b0;
        end else begin
            err_overrun_q <= err_overrun_d;
        end
    end

    assign err_overrun = err_overrun_q;
`else
    assign err_overrun = 1'b0;
`endif

    assign rom_addr   = rom_addr_q;
    assign fifo_rst_n = fifo_rst_n_q;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_morph_window_seq.sv
// Directed bench for morph_window_seq on an 8x8 picture with ROM_LAT=2.
module tb_morph_window_seq;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int AW  = 16;
    localparam int LAT = 2;
    localparam int RC  = 4;
`ifdef MORPH_SEQ_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          line_req = 1'b0;
    logic          fifo_rst_busy = 1'b0;
    logic [AW-1:0] rom_addr;
    logic          buf_wr_en, buf_rd_en, win_valid, fifo_rst_n;
    logic          line_done, frame_done, busy, err_overrun;

    morph_window_seq #(
        .PIC_WIDTH  (W),
        .PIC_HEIGHT (H),
        .ADDR_W     (AW),
        .ROM_LAT    (LAT),
        .RST_CYC    (RC)
    ) dut (
        .lcd_pclk      (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .line_req      (line_req),
        .fifo_rst_busy (fifo_rst_busy),
        .rom_addr      (rom_addr),
        .buf_wr_en     (buf_wr_en),
        .buf_rd_en     (buf_rd_en),
        .win_valid     (win_valid),
        .fifo_rst_n    (fifo_rst_n),
        .line_done     (line_done),
        .frame_done    (frame_done),
        .busy          (busy),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Monitor on the falling edge: counts enables, checks that each written
    // beat carries the address issued LAT cycles earlier, in sequence from 0.
    int wr_cnt = 0, rd_cnt = 0, win_cnt = 0, ld_cnt = 0, fd_cnt = 0;
    int rstlow_cnt = 0, seq_err = 0, rd_err = 0, win_err = 0, run_err = 0, run_len = 0;
    logic [AW-1:0] hist0 = '0, hist1 = '0, exp_addr = '0;
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        if (!fifo_rst_n) begin
            rstlow_cnt++;
            exp_addr = '0;
        end
        if (buf_wr_en) begin
            wr_cnt++;
            if (hist1 != exp_addr) seq_err++;
            exp_addr = exp_addr + 1'b1;
        end
        hist1 = hist0;
        hist0 = rom_addr;
        if (buf_rd_en) begin
            rd_cnt++;
            if (!buf_wr_en) rd_err++;
        end
        if (win_valid !== prev_rd) win_err++;
        prev_rd = buf_rd_en;
        if (win_valid) begin
            win_cnt++;
            run_len++;
        end else begin
            if (run_len != 0 && run_len != W) run_err++;
            run_len = 0;
        end
        if (line_done) ld_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_lr();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 200 && busy; i++) tick();
        chk(tag, busy, 0);
        repeat (4) tick();
    endtask

    task automatic wait_line_done(input string tag);
        for (int i = 0; i < 50 && !line_done; i++) tick();
        chk(tag, line_done, 1);
    endtask

    int ld0, rd0;

    initial begin
        repeat (3) tick();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_wr_en", buf_wr_en, 0);
        chk("rst_rd_en", buf_rd_en, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_fifo_rst_n", fifo_rst_n, 1);
        chk("rst_line_done", line_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_overrun", err_overrun, 0);
        rst_n = 1'b1;
        tick();

        // FIFO reset held busy: sequencer parks in WAIT_RB
        fifo_rst_busy = 1'b1;
        pulse_fs();
        chk("flush_entry_fifo_rst_n", fifo_rst_n, 0);
        repeat (20) tick();
        chk("wait_rb_busy", busy, 1);
        chk("wait_rb_no_wr", wr_cnt, 0);
        chk("wait_rb_addr", rom_addr, 0);
        chk("flush_len", rstlow_cnt, RC);
        chk("wait_rb_fifo_rst_n", fifo_rst_n, 1);

        // Preload with a stray line_req in the middle
        fifo_rst_busy = 1'b0;
        repeat (3) tick();
        pulse_lr();
        wait_ready("preload_ready");
        chk("preload_wr_cnt", wr_cnt, 2 * W);
        chk("preload_rd_cnt", rd_cnt, 0);
        chk("preload_last_addr", rom_addr, 2 * W - 1);
        chk("preload_err_overrun", err_overrun, OVR);
        chk("preload_no_line", ld_cnt, 0);
        chk("preload_seq", seq_err, 0);

        // Full frame of H-2 lines
        for (int i = 0; i < H - 2; i++) begin
            pulse_lr();
            if (i == 0) chk("line_first_addr", rom_addr, 2 * W);
            wait_line_done("line_done_seen");
            chk("line_last_addr", rom_addr, 2 * W + W * i + W - 1);
            chk("frame_done_at_line", frame_done, (i == H - 3) ? 1 : 0);
        end
        repeat (6) tick();
        chk("frame_rd_cnt", rd_cnt, (H - 2) * W);
        chk("frame_win_cnt", win_cnt, (H - 2) * W);
        chk("frame_wr_cnt", wr_cnt, H * W);
        chk("frame_seq", seq_err, 0);
        chk("frame_rd_wr_align", rd_err, 0);
        chk("frame_win_delay", win_err, 0);
        chk("frame_win_runs", run_err, 0);
        chk("frame_line_done_cnt", ld_cnt, H - 2);
        chk("frame_done_cnt", fd_cnt, 1);
        chk("frame_final_addr", rom_addr, W * H - 1);
        chk("frame_idle_busy", busy, 0);
        chk("frame_err_sticky", err_overrun, OVR);

        // Abort mid-LINE at column 3
        pulse_fs();
        chk("new_frame_err_clear", err_overrun, 0);
        wait_ready("abort_pre_ready");
        ld0 = ld_cnt;
        pulse_lr();
        for (int i = 0; i < 20 && rom_addr != 2 * W + 3; i++) tick();
        chk("abort_col3_addr", rom_addr, 2 * W + 3);
        pulse_fs();
        chk("abort_fifo_rst_n", fifo_rst_n, 0);
        chk("abort_wr_en", buf_wr_en, 0);
        chk("abort_rd_en", buf_rd_en, 0);
        tick();
        chk("abort_win_valid", win_valid, 0);
        wait_ready("abort_reload_ready");
        chk("abort_reload_addr", rom_addr, 2 * W - 1);
        chk("abort_reload_seq", seq_err, 0);
        chk("abort_no_line_done", ld_cnt, ld0);

        // frame_start beats a simultaneous line_req in READY
        rd0 = rd_cnt;
        frame_start = 1'b1;
        line_req = 1'b1;
        tick();
        frame_start = 1'b0;
        line_req = 1'b0;
        chk("fs_lr_fifo_rst_n", fifo_rst_n, 0);
        chk("fs_lr_busy", busy, 1);
        wait_ready("fs_lr_ready");
        chk("fs_lr_no_rd", rd_cnt, rd0);
        chk("fs_lr_addr", rom_addr, 2 * W - 1);
        chk("fs_lr_no_line_done", ld_cnt, ld0);
        chk("fs_lr_err", err_overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
